// File: rtl/nios_mul_pkg.sv
// Shared definitions for the Nios multi-cycle multiply sequencer:
// op encodings, FSM states, partial-product pair order and shift table.
package nios_mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXSS = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXUU = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_SIGN,
        ST_RESP
    } state_t;

    // Pair index bit 1 selects the A half, bit 0 selects the B half.
    localparam logic [1:0] PAIR_LL = 2'd0;
    localparam logic [1:0] PAIR_LH = 2'd1;
    localparam logic [1:0] PAIR_HL = 2'd2;
    localparam logic [1:0] PAIR_HH = 2'd3;

    function automatic logic [5:0] pair_shift(input logic [1:0] pair);
        logic [5:0] sh;
        case (pair)
            PAIR_LL: sh = 6'd0;
            PAIR_LH: sh = 6'd16;
            PAIR_HL: sh = 6'd16;
            default: sh = 6'd32;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/nios_mul16_cell.sv
// Registered 16x16 unsigned multiplier cell; one-cycle latency, clock enable
// and synchronous clear so it maps onto a single DSP multiplier.
module nios_mul16_cell (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    always_ff @(posedge clk) begin
        if (clr) begin
            p <= '0;
        end else if (en) begin
            p <= a * b;
        end
    end

endmodule

// File: rtl/nios_mul_seq.sv
// 32x32 multiply sequencer: magnitudes are multiplied through one shared
// 16x16 cell, partials accumulated in 64 bits, then sign-corrected.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | ready for a request; latches op, sign flags, magnitudes
// ISSUE    | drives pair cnt into the cell, accumulates previous pair
// DRAIN    | accumulates the last pair; cell idle
// SIGN     | negates acc when exactly one operand was negative
// RESP     | holds result until rsp_ready
module nios_mul_seq
    import nios_mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result
);

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    op_t         op_q;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [63:0] acc;

    logic        cell_en;
    logic [15:0] cell_a, cell_b;
    logic [31:0] cell_p;
    logic [1:0]  last_pair;
    logic [63:0] partial;
    logic        issue_last;
    logic        acc_en;

    op_t         in_op;
    logic        in_a_neg, in_b_neg;

    assign in_op    = op_t'(req_op);
    assign in_a_neg = req_a[31] & ((in_op == OP_MULXSS) | (in_op == OP_MULXSU));
    assign in_b_neg = req_b[31] & (in_op == OP_MULXSS);

    assign cell_a = cnt[1] ? a_mag[31:16] : a_mag[15:0];
    assign cell_b = cnt[0] ? b_mag[31:16] : b_mag[15:0];

    nios_mul16_cell u_cell (
        .clk (clk),
        .clr (reset),
        .en  (cell_en),
        .a   (cell_a),
        .b   (cell_b),
        .p   (cell_p)
    );

    // The cell output always belongs to the pair issued one cycle earlier.
    assign last_pair  = cnt[1:0] - 2'd1;
    assign partial    = {32'b0, cell_p} << pair_shift(last_pair);
    assign issue_last = (op_q == OP_MUL) ? (cnt == 3'd2) : (cnt == 3'd3);
    assign acc_en     = ((state == ST_ISSUE) && (cnt != 3'd0)) || (state == ST_DRAIN);

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        cell_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                cell_en = 1'b1;
                if (issue_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_nxt = (op_q == OP_MUL) ? ST_RESP : ST_SIGN;
            end
            ST_SIGN: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= OP_MUL;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            a_mag <= '0;
            b_mag <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q  <= in_op;
                        a_neg <= in_a_neg;
                        b_neg <= in_b_neg;
                        a_mag <= in_a_neg ? (32'd0 - req_a) : req_a;
                        b_mag <= in_b_neg ? (32'd0 - req_b) : req_b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                ST_ISSUE: begin
                    cnt <= cnt + 3'd1;
                    if (acc_en) acc <= acc + partial;
                end
                ST_DRAIN: begin
                    acc <= acc + partial;
                end
                ST_SIGN: begin
                    if (a_neg ^ b_neg) acc <= 64'd0 - acc;
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_result = (op_q == OP_MUL) ? acc[31:0] : acc[63:32];

endmodule

// File: tb/tb_nios_mul_seq.sv
// Scoreboard bench for nios_mul_seq: expected results are computed from
// sign-extended 64-bit products and queued at request acceptance.
module tb_nios_mul_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          t_req = 0;
    logic [31:0] exp_q[$];

    nios_mul_seq dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = {32'b0, a};
        xb = {32'b0, b};
        if (op == 2'b01 || op == 2'b10) xa = {{32{a[31]}}, a};
        if (op == 2'b01) xb = {{32{b[31]}}, b};
        p = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Called at a negedge; returns at the negedge of cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        t_req     = cyc;
        if (push) exp_q.push_back(ref_mul(op, a, b));
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", req_ready, 0);
    endtask

    // Waits for rsp_valid, checks latency and data, optionally stalls rsp_ready
    // while offering a request that must be ignored. Returns at negedge R+1.
    task automatic collect(input int lat, input int hold);
        int n;
        logic [31:0] exp, held;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        chk("latency", cyc - t_req, lat);
        if (exp_q.size() == 0) begin
            chk("unexpected_rsp", rsp_result, 32'hx);
            return;
        end
        exp = exp_q.pop_front();
        chk("result", rsp_result, exp);
        held = rsp_result;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_op    = 2'b11;
            req_a     = 32'h1234_5678;
            req_b     = 32'h9abc_def0;
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_stable", rsp_result, held);
            chk("bp_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_ready", req_ready, 1);
        chk("post_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);

        issue(2'b00, 32'h0001_0003, 32'h0002_0005, 1);
        chk("mul_vector", exp_q[0], 32'h000B_000F);
        collect(5, 0);

        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        collect(7, 0);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        collect(5, 0);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1);
        collect(7, 0);
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 1);
        collect(7, 0);
        issue(2'b10, 32'hFFFF_FFFE, 32'h8000_0000, 1);
        collect(7, 0);
        issue(2'b10, 32'h0000_0002, 32'h8000_0000, 1);
        collect(7, 0);

        // Backpressure, ignored request, then back-to-back MUL.
        issue(2'b01, 32'h8765_4321, 32'h0FED_CBA9, 1);
        collect(7, 3);
        issue(2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1);
        collect(5, 0);

        // Reset in the middle of a MULXSS.
        issue(2'b01, 32'hF000_0001, 32'h7000_0003, 0);
        @(negedge clk);
        chk("mid_rsp_valid_t2", rsp_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_req_ready", req_ready, 1);
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_rsp_result", rsp_result, 0);
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_no_rsp", rsp_valid, 0);
            @(negedge clk);
        end
        issue(2'b11, 32'h0001_0000, 32'h0001_0000, 1);
        collect(7, 0);

        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if (i == 0) a = 32'h8000_0000;
            if (i == 1) b = 32'h8000_0000;
            issue(op, a, b, 1);
            collect((op == 2'b00) ? 5 : 7, i % 3);
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
